// File: rtl/rv32_dmem_pkg.sv
// Shared types for the RV32 data-memory target: FSM state encoding and byte-lane masks.
// Build option: define RV32_DMEM_FAULT_EN to enable out-of-range access faults in the top.
package rv32_dmem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } dmem_state_e;

    localparam logic [3:0] MASK_NONE  = 4'b0000;
    localparam logic [3:0] MASK_ALL   = 4'b1111;
    localparam logic [3:0] MASK_LANE0 = 4'b0001;
    localparam logic [3:0] MASK_LANE1 = 4'b0010;
    localparam logic [3:0] MASK_LANE2 = 4'b0100;
    localparam logic [3:0] MASK_LANE3 = 4'b1000;

    function automatic logic [3:0] lane_mask(input int lane);
        logic [3:0] m;
        m = MASK_NONE;
        case (lane)
            0:       m = MASK_LANE0;
            1:       m = MASK_LANE1;
            2:       m = MASK_LANE2;
            3:       m = MASK_LANE3;
            default: m = MASK_NONE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/rv32_dmem_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// Contents are never reset; the read register only changes on a read.
module rv32_dmem_ram
    import rv32_dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           read_en,
    input  logic [3:0]                     write_mask,
    input  logic [$clog2(DEPTH_WORDS)-1:0] index,
    input  logic [31:0]                    write_value,
    output logic [31:0]                    read_value
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int lane = 0; lane < 4; lane++) begin
            if ((write_mask & lane_mask(lane)) != MASK_NONE) begin
                mem[index][lane*8 +: 8] <= write_value[lane*8 +: 8];
            end
        end
        if (read_en) begin
            read_value <= mem[index];
        end
    end

endmodule

// File: rtl/rv32_dmem_target.sv
// RV32 data-memory target: single-cycle writes, two-cycle reads through an IDLE/RESP FSM.
// Define RV32_DMEM_FAULT_EN to range-check addresses and raise data_fault_out on misses.
module rv32_dmem_target
    import rv32_dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_address_in,
    input  logic        data_read_in,
    input  logic        data_write_in,
    input  logic [3:0]  data_write_mask_in,
    input  logic [31:0] data_write_value_in,
    output logic [31:0] data_read_value_out,
    output logic        data_ready_out,
    output logic        data_fault_out,
    output dmem_state_e dbg_state
);

    localparam int AW = $clog2(DEPTH_WORDS);

    dmem_state_e   state;
    dmem_state_e   state_next;
    logic [31:0]   rdata_q;
    logic [31:0]   ram_rdata;
    logic [AW-1:0] ram_index;
    logic          ram_read_en;
    logic [3:0]    ram_write_mask;
    logic          in_range;

`ifdef RV32_DMEM_FAULT_EN
    localparam logic [31:0] RANGE_BYTES = 32'(4 * DEPTH_WORDS);

    logic [31:0] offset;
    logic        unused_offset_bits;

    // Unsigned subtraction: addresses below BASE_ADDR wrap high and fail the compare.
    assign offset             = data_address_in - BASE_ADDR;
    assign in_range           = offset < RANGE_BYTES;
    assign ram_index          = offset[AW+1:2];
    assign unused_offset_bits = ^{offset[31:AW+2], offset[1:0]};
`else
    localparam logic [31:0] UNUSED_BASE_ADDR = BASE_ADDR;

    logic unused_addr_bits;

    // No range check: upper address bits are ignored, so accesses wrap modulo RAM size.
    assign in_range         = 1'b1;
    assign ram_index        = data_address_in[AW+1:2];
    assign unused_addr_bits = ^{data_address_in[31:AW+2], data_address_in[1:0], UNUSED_BASE_ADDR};
`endif

    always_comb begin
        state_next     = state;
        ram_read_en    = 1'b0;
        ram_write_mask = MASK_NONE;
        data_ready_out = 1'b1;
        data_fault_out = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    // A write wins over a simultaneous read.
                    if (data_write_in) begin
                        if (in_range) begin
                            ram_write_mask = data_write_mask_in;
                        end else begin
                            data_fault_out = 1'b1;
                        end
                    end else if (data_read_in) begin
                        if (in_range) begin
                            ram_read_en    = 1'b1;
                            data_ready_out = 1'b0;
                            state_next     = RESP;
                        end else begin
                            data_fault_out = 1'b1;
                        end
                    end
                end
                RESP: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rdata_q <= '0;
        end else begin
            state <= state_next;
            if (state == RESP) begin
                rdata_q <= ram_rdata;
            end
        end
    end

    // RAM output is presented directly in RESP so the core sees data while ready is high.
    assign data_read_value_out = (state == RESP && !reset) ? ram_rdata : rdata_q;
    assign dbg_state           = state;

    rv32_dmem_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk        (clk),
        .read_en    (ram_read_en),
        .write_mask (ram_write_mask),
        .index      (ram_index),
        .write_value(data_write_value_in),
        .read_value (ram_rdata)
    );

endmodule

// File: doc/rv32_dmem_target.md
RV32_DMEM_TARGET -- requirements
Module: rv32_dmem_target

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words of backing RAM (power of two).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0001_0000, byte address of word 0 (aligned to 4*DEPTH_WORDS).
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port data_address_in, input, 32, word-aligned byte address from the memory stage.
REQ-006 SHALL have port data_read_in, input, 1, read request.
REQ-007 SHALL have port data_write_in, input, 1, write request.
REQ-008 SHALL have port data_write_mask_in, input, 4, byte enables; bit i writes byte lane i.
REQ-009 SHALL have port data_write_value_in, input, 32, write data, lane-positioned.
REQ-010 SHALL have port data_read_value_out, output, 32, registered read data.
REQ-011 SHALL have port data_ready_out, output, 1, request complete this cycle; low means the core must stall.
REQ-012 SHALL have port data_fault_out, output, 1, access fault for the current request.

Function
REQ-013 SHALL implement FSM states IDLE and RESP.
REQ-014 Request protocol: the core holds address/read/write/mask/value stable while data_ready_out=0.
REQ-015 In-range: (addr - BASE_ADDR) < 4*DEPTH_WORDS, unsigned 32-bit subtraction; index = (addr - BASE_ADDR)[log2(DEPTH)+1:2].
REQ-016 IDLE, no request: data_ready_out=1, data_fault_out=0, no RAM access, stay IDLE.
REQ-017 IDLE, write in-range: bytes with mask=1 written at the clock edge; data_ready_out=1 same cycle; stay IDLE; data_read_value_out unchanged.
REQ-018 IDLE, read in-range: RAM read issued; data_ready_out=0; next state RESP.
REQ-019 RESP: data_read_value_out = RAM word read (all 32 bits, no lane extraction); data_ready_out=1; next state IDLE unconditionally.
REQ-020 Read latency is exactly 2 cycles from the first cycle of the request; back-to-back reads complete every 2 cycles.
REQ-021 Read and write both asserted: treated as write only, per REQ-017.
REQ-022 data_read_value_out holds its last value at all times other than the RESP update.
REQ-023 Request withdrawn in RESP (e.g. pipeline flush): RESP still returns to IDLE; no side effect.
REQ-024 A write repeated across stalled cycles rewrites identical data (idempotent); no write buffering.
REQ-025 data_write_mask_in=0 with write asserted: no bytes modified; ready=1.

Reset
REQ-026 Reset SHALL force state IDLE, data_read_value_out=0, and abort any in-flight read.
REQ-027 During reset: data_ready_out=1, data_fault_out=0, no RAM write; RAM contents not cleared.
REQ-028 Reset asserted in RESP: next cycle IDLE, no read data delivered.

Configuration
REQ-029 Macro RV32_DMEM_FAULT_EN defined: out-of-range request in IDLE → data_fault_out=1 and data_ready_out=1 same cycle, no RAM access, stay IDLE, data_read_value_out unchanged.
REQ-030 Macro RV32_DMEM_FAULT_EN undefined: data_fault_out tied 0; the address range check is omitted; index = addr[log2(DEPTH)+1:2] (wraps modulo RAM size).

Structure
REQ-031 Package rv32_dmem_pkg SHALL hold the state enum (IDLE, RESP) and the byte-lane mask constants.
REQ-032 Sub-module rv32_dmem_ram SHALL be used: single-port RAM, synchronous read, per-byte write enable, no reset.

Verification
REQ-033 Write 0xDEADBEEF to BASE_ADDR with mask 1111, then read BASE_ADDR → ready=0 then 1; data 0xDEADBEEF on the 2nd cycle.
REQ-034 Write 0x0000AA00 to BASE+4 with mask 0010 over 0x11223344 → read returns 0x1122AA44.
REQ-035 Read BASE+0x4000 with FAULT_EN defined, DEPTH=1024 → fault=1, ready=1 same cycle, state stays IDLE; without FAULT_EN → returns word 0 data, 2-cycle latency.
REQ-036 Reset asserted during RESP of a read of 0x55AA55AA → data_read_value_out=0, ready=1, state IDLE next cycle.
REQ-037 Four back-to-back reads → ready pattern 0,1,0,1,0,1,0,1 with correct data each.
REQ-038 Read and write asserted together on BASE+8 with 0x12345678, mask 1111 → ready=1 same cycle; a subsequent read returns 0x12345678.
